// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// FIFO geometry common with the FIFO itself.
package fifo_wr_arbiter_pkg;

    localparam int DEPTH   = 8;
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RETRY = 2'b11
    } arbState_t;

    // data_count == DEPTH is the FIFO's full condition
    function automatic logic isFull(input logic [COUNT_W-1:0] dataCount);
        return dataCount == COUNT_W'(DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational 2-way round-robin selector; pointer picks the winner only
// when both requesters are active.
module fifo_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic sel,
    output logic valid
);

    assign valid = req0 | req1;
    assign sel   = (req0 & req1) ? pointer : req1;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between two producers.
// Optional statistics counters are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int TIMEOUT   = 4,
    parameter int MAX_RETRY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          err0,
    output logic          err1,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_full,
    input  logic          fifo_wr_ack,
    input  logic          fifo_wr_err,
    output logic          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]   acc_cnt0,
    output logic [15:0]   acc_cnt1,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arbState_t      r_state;
    logic           r_owner;
    logic           r_ptr;
    logic [RW-1:0]  r_retry;
    logic [TW-1:0]  r_tmo;
    logic [DW-1:0]  r_din;
    logic           r_wrEn;
    logic           r_busy;
    logic           r_gnt0;
    logic           r_gnt1;
    logic           r_err0;
    logic           r_err1;
    logic           w_sel;
    logic           w_valid;
    logic           w_ownerReq;

    fifo_rr_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .pointer (r_ptr),
        .sel     (w_sel),
        .valid   (w_valid)
    );

    assign w_ownerReq = r_owner ? req1 : req0;

    // All outputs are registered; a response outranks the timeout in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_din   <= '0;
            r_wrEn  <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_wrEn <= 1'b0;
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            r_busy <= (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (!fifo_full && w_valid) begin
                        r_owner <= w_sel;
                        r_din   <= w_sel ? din1 : din0;
                        r_retry <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wrEn  <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (fifo_wr_ack) begin
                        r_gnt0  <= ~r_owner;
                        r_gnt1  <= r_owner;
                        r_ptr   <= ~r_owner;
                        r_retry <= '0;
                        r_state <= IDLE;
                    end else if (fifo_wr_err && (r_retry < RW'(MAX_RETRY))) begin
                        r_retry <= r_retry + RW'(1);
                        r_state <= RETRY;
                    end else if (fifo_wr_err || (r_tmo == TW'(TIMEOUT))) begin
                        r_err0  <= ~r_owner;
                        r_err1  <= r_owner;
                        r_ptr   <= ~r_owner;
                        r_retry <= '0;
                        r_state <= IDLE;
                    end
                end
                RETRY: begin
                    if (!w_ownerReq) begin
                        r_retry <= '0;
                        r_state <= IDLE;
                    end else if (!fifo_full) begin
                        r_state <= ISSUE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign err0       = r_err0;
    assign err1       = r_err1;
    assign fifo_wr_en = r_wrEn;
    assign fifo_din   = r_din;
    assign busy       = r_busy;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_acc0;
    logic [15:0] r_acc1;
    logic [15:0] r_drop;

    // Saturating counters follow the registered completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
            r_drop <= '0;
        end else begin
            if (r_gnt0 && (r_acc0 != 16'hFFFF)) r_acc0 <= r_acc0 + 16'd1;
            if (r_gnt1 && (r_acc1 != 16'hFFFF)) r_acc1 <= r_acc1 + 16'd1;
            if ((r_err0 || r_err1) && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end

    assign acc_cnt0 = r_acc0;
    assign acc_cnt1 = r_acc1;
    assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int TIMEOUT   = 4;
    localparam int MAX_RETRY = 1;

    logic       clk;
    logic       reset;
    logic       req0;
    logic       req1;
    logic [7:0] din0;
    logic [7:0] din1;
    logic       gnt0;
    logic       gnt1;
    logic       err0;
    logic       err1;
    logic       fifo_wr_en;
    logic [7:0] fifo_din;
    logic       fifo_full;
    logic       fifo_wr_ack;
    logic       fifo_wr_err;
    logic       busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] acc_cnt0;
    logic [15:0] acc_cnt1;
    logic [15:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    fifo_wr_arbiter #(
        .DW        (8),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .din0        (din0),
        .din1        (din1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .err0        (err0),
        .err1        (err1),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .fifo_wr_ack (fifo_wr_ack),
        .fifo_wr_err (fifo_wr_err),
        .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .acc_cnt0    (acc_cnt0),
        .acc_cnt1    (acc_cnt1),
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // resp codes: 0 none, 1 ack, 2 err, 3 ack+err; pulse codes: 0 gnt0, 1 gnt1, 2 err0, 3 err1
    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] resp1;
        logic [1:0] resp2;
        logic [7:0] expData;
        int         expStrobes;
        int         expPulse;
        int         expCycle;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
        req0 = r0;
        req1 = r1;
        din0 = d0;
        din1 = d1;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        fifo_full   = 1'b0;
        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        reset = 1'b0;
    endtask

    // One transaction from the current cycle (called cycle 0); the FIFO answers one cycle after each strobe.
    task automatic runTxn(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] resp1, input logic [1:0] resp2,
                          output int firstWr, output logic [7:0] wrData, output int strobes,
                          output int pulseKind, output int pulseCycle, output int pulses,
                          output int busyAtPulse, output int busyAfter, output int dataChanged);
        logic       pend;
        logic [1:0] pendKind;
        pend        = 1'b0;
        pendKind    = 2'b00;
        firstWr     = -1;
        wrData      = 8'h00;
        strobes     = 0;
        pulseKind   = -1;
        pulseCycle  = -1;
        pulses      = 0;
        busyAtPulse = -1;
        busyAfter   = -1;
        dataChanged = 0;
        applyStimulus(r0, r1, d0, d1);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            fifo_wr_ack = 1'b0;
            fifo_wr_err = 1'b0;
            if (pend) begin
                fifo_wr_ack = pendKind[0];
                fifo_wr_err = pendKind[1];
                pend = 1'b0;
            end
            if (fifo_wr_en) begin
                strobes++;
                if (firstWr < 0) begin
                    firstWr = cyc;
                    wrData  = fifo_din;
                end else if (fifo_din !== wrData) begin
                    dataChanged = 1;
                end
                pendKind = (strobes == 1) ? resp1 : resp2;
                pend     = 1'b1;
            end
            if (cyc == pulseCycle + 1) busyAfter = int'(busy);
            if (gnt0 || gnt1 || err0 || err1) begin
                pulses += int'(gnt0) + int'(gnt1) + int'(err0) + int'(err1);
                if (pulseKind < 0) begin
                    pulseKind   = gnt0 ? 0 : gnt1 ? 1 : err0 ? 2 : 3;
                    pulseCycle  = cyc;
                    busyAtPulse = int'(busy);
                end
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
    endtask

    task automatic tableTest();
        int         firstWr, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged;
        logic [7:0] wrData;
        vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 2'd1, 2'd0, 8'hA5, 1, 0, 4};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 2'd1, 2'd0, 8'h3C, 1, 1, 4};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'd1, 2'd0, 8'h11, 1, 0, 4};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h5A, 2'd3, 2'd0, 8'h5A, 1, 1, 4};
        vecs[4] = '{1'b1, 1'b0, 8'hC3, 8'h00, 2'd2, 2'd2, 8'hC3, 2, 2, 8};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h7E, 2'd2, 2'd1, 8'h7E, 2, 1, 8};
        vecs[6] = '{1'b1, 1'b0, 8'h96, 8'h00, 2'd0, 2'd0, 8'h96, 1, 2, 3 + TIMEOUT};
        vecs[7] = '{1'b1, 1'b1, 8'h01, 8'h02, 2'd0, 2'd0, 8'h01, 1, 2, 3 + TIMEOUT};
        for (int i = 0; i < 8; i++) begin
            doReset();
            runTxn(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].resp1, vecs[i].resp2,
                   firstWr, wrData, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged);
            checkOutput($sformatf("vec%0d_firstWrEnCycle", i), firstWr, 2);
            checkOutput($sformatf("vec%0d_fifoDin", i), int'(wrData), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_strobes", i), strobes, vecs[i].expStrobes);
            checkOutput($sformatf("vec%0d_pulseKind", i), pulseKind, vecs[i].expPulse);
            checkOutput($sformatf("vec%0d_pulseCycle", i), pulseCycle, vecs[i].expCycle);
            checkOutput($sformatf("vec%0d_pulseCount", i), pulses, 1);
            checkOutput($sformatf("vec%0d_busyAtPulse", i), busyAtPulse, 1);
            checkOutput($sformatf("vec%0d_busyAfter", i), busyAfter, 0);
            checkOutput($sformatf("vec%0d_retryDataStable", i), dataChanged, 0);
        end
    endtask

    task automatic fullGateTest();
        int wrCnt;
        int busyCnt;
        wrCnt   = 0;
        busyCnt = 0;
        doReset();
        fifo_full = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'hE7);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            wrCnt   += int'(fifo_wr_en);
            busyCnt += int'(busy);
        end
        checkOutput("full_wrEnWhileFull", wrCnt, 0);
        checkOutput("full_busyWhileFull", busyCnt, 0);
        fifo_full = 1'b0;
        step();
        checkOutput("full_wrEnAfter1", int'(fifo_wr_en), 0);
        step();
        checkOutput("full_wrEnAfter2", int'(fifo_wr_en), 1);
        checkOutput("full_fifoDin", int'(fifo_din), 8'hE7);
        step();
        fifo_wr_ack = 1'b1;
        step();
        fifo_wr_ack = 1'b0;
        checkOutput("full_gnt1", int'(gnt1), 1);
        req1 = 1'b0;
        step();
    endtask

    task automatic alternationTest();
        int   order[4];
        int   gcount;
        logic pend;
        gcount = 0;
        pend   = 1'b0;
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h10, 8'h20);
        for (int cyc = 1; cyc <= 60 && gcount < 4; cyc++) begin
            step();
            fifo_wr_ack = pend;
            pend = fifo_wr_en;
            if (gnt0 || gnt1) begin
                order[gcount] = int'(gnt1);
                gcount++;
                if (gnt0) din0 = din0 + 8'd1;
                else      din1 = din1 + 8'd1;
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        fifo_wr_ack = 1'b0;
        step();
        step();
        checkOutput("alt_grantCount", gcount, 4);
        for (int k = 0; k < gcount; k++) checkOutput($sformatf("alt_order%0d", k), order[k], k % 2);
    endtask

    task automatic pointerAfterErrTest();
        int         firstWr, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged;
        logic [7:0] wrData;
        doReset();
        runTxn(1'b1, 1'b0, 8'hC3, 8'h00, 2'd2, 2'd2,
               firstWr, wrData, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged);
        checkOutput("ptr_errPulse", pulseKind, 2);
        runTxn(1'b1, 1'b1, 8'h44, 8'h55, 2'd1, 2'd0,
               firstWr, wrData, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged);
        checkOutput("ptr_req1Wins", pulseKind, 1);
        checkOutput("ptr_req1Data", int'(wrData), 8'h55);
    endtask

    task automatic resetInWaitTest();
        int pulses;
        int strobes;
        pulses  = 0;
        strobes = 0;
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
        step();
        step();
        checkOutput("rstWait_wrEn", int'(fifo_wr_en), 1);
        step();
        checkOutput("rstWait_busyInWait", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("rstWait_busy", int'(busy), 0);
        checkOutput("rstWait_fifoDin", int'(fifo_din), 0);
        checkOutput("rstWait_pulses", int'(gnt0) + int'(gnt1) + int'(err0) + int'(err1) + int'(fifo_wr_en), 0);
        req0 = 1'b0;
        step();
        reset       = 1'b0;
        fifo_wr_ack = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            fifo_wr_ack = 1'b0;
            pulses  += int'(gnt0) + int'(gnt1) + int'(err0) + int'(err1);
            strobes += int'(fifo_wr_en);
        end
        checkOutput("rstWait_noPulseAfter", pulses, 0);
        checkOutput("rstWait_noStrobeAfter", strobes, 0);
    endtask

    // Transaction-level model: queued words per producer, alternate when both wait, MAX_RETRY+1 tries per word.
    task automatic randomTest();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        int         ptrM, owner, attempts, expOut, cnt, nPulse, actCode, expCode, n0, n1;
        logic       inTxn, armed;
        logic [1:0] kind, armedKind;
        int         d;
        ptrM      = 0;
        owner     = 0;
        attempts  = 0;
        expOut    = 0;
        cnt       = 0;
        inTxn     = 1'b0;
        armed     = 1'b0;
        armedKind = 2'b00;
        n0 = $urandom_range(4, 10);
        n1 = $urandom_range(4, 10);
        for (int i = 0; i < n0; i++) q0.push_back({1'b0, 7'($urandom)});
        for (int i = 0; i < n1; i++) q1.push_back({1'b1, 7'($urandom)});
        doReset();
        applyStimulus(1'b1, 1'b1, q0[0], q1[0]);
        for (int cyc = 0; cyc < 3000 && !(q0.size() == 0 && q1.size() == 0 && !inTxn); cyc++) begin
            step();
            fifo_full   = ($urandom_range(0, 3) == 0);
            fifo_wr_ack = 1'b0;
            fifo_wr_err = 1'b0;
            if (armed) begin
                cnt--;
                if (cnt == 0) begin
                    fifo_wr_ack = armedKind[0];
                    fifo_wr_err = armedKind[1];
                    armed = 1'b0;
                end
            end
            if (fifo_wr_en) begin
                if (!inTxn) begin
                    owner    = (q0.size() != 0 && q1.size() != 0) ? ptrM : ((q0.size() != 0) ? 0 : 1);
                    inTxn    = 1'b1;
                    attempts = 0;
                end
                attempts++;
                checkOutput("rnd_fifoDin", int'(fifo_din), int'((owner == 1) ? q1[0] : q0[0]));
                kind = 2'($urandom_range(0, 3));
                d    = $urandom_range(0, 3);
                if (kind[0])                              expOut = 1;
                else if (kind[1] && attempts <= MAX_RETRY) expOut = 0;
                else                                      expOut = 2;
                if (d == 0) begin
                    fifo_wr_ack = kind[0];
                    fifo_wr_err = kind[1];
                end else begin
                    armed     = 1'b1;
                    armedKind = kind;
                    cnt       = d;
                end
            end
            nPulse = int'(gnt0) + int'(gnt1) + int'(err0) + int'(err1);
            if (nPulse != 0) begin
                checkOutput("rnd_singlePulse", nPulse, 1);
                actCode = gnt0 ? 0 : gnt1 ? 1 : err0 ? 2 : 3;
                expCode = !inTxn ? -1 : (expOut == 1) ? owner : (expOut == 2) ? owner + 2 : -1;
                checkOutput("rnd_pulse", actCode, expCode);
                if (inTxn) begin
                    if (owner == 1) void'(q1.pop_front());
                    else            void'(q0.pop_front());
                    ptrM  = 1 - owner;
                    inTxn = 1'b0;
                end
                req0 = (q0.size() != 0);
                req1 = (q1.size() != 0);
                if (q0.size() != 0) din0 = q0[0];
                if (q1.size() != 0) din1 = q1[0];
            end
        end
        checkOutput("rnd_drained", q0.size() + q1.size() + int'(inTxn), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        fifo_full   = 1'b0;
        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
        step();
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic statsTest();
        int         firstWr, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged;
        logic [7:0] wrData;
        doReset();
        for (int i = 0; i < 3; i++)
            runTxn(1'b1, 1'b0, 8'(i + 1), 8'h00, 2'd1, 2'd0,
                   firstWr, wrData, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged);
        runTxn(1'b1, 1'b0, 8'hEE, 8'h00, 2'd0, 2'd0,
               firstWr, wrData, strobes, pulseKind, pulseCycle, pulses, busyAtPulse, busyAfter, dataChanged);
        checkOutput("stats_accCnt0", int'(acc_cnt0), 3);
        checkOutput("stats_accCnt1", int'(acc_cnt1), 0);
        checkOutput("stats_dropCnt", int'(drop_cnt), 1);
    endtask
`endif

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        fifo_full   = 1'b0;
        fifo_wr_ack = 1'b0;
        fifo_wr_err = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_outputs", int'(gnt0) + int'(gnt1) + int'(err0) + int'(err1) + int'(fifo_wr_en) + int'(busy), 0);
        checkOutput("reset_fifoDin", int'(fifo_din), 0);
        tableTest();
        fullGateTest();
        alternationTest();
        pointerAfterErrTest();
        resetInWaitTest();
        randomTest();
`ifdef FIFO_WR_ARB_STATS_EN
        statsTest();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
